// File: rtl/puf_crp_controller.sv
// Challenge-response initiator for an 8-bit-challenge arbiter/XOR PUF: LFSR challenges,
// one launch edge per challenge, synchronised response sampling, word packing and handoff.
module puf_crp_controller #(
  parameter int         RESP_BITS  = 16,
  parameter int         SETTLE_CYC = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 seed_load_i,
  input  logic [7:0]           seed_i,
  output logic [7:0]           ch_o,
  output logic                 puf_in_o,
  output logic                 arb_clr_o,
  input  logic                 puf_resp_i,
  output logic [RESP_BITS-1:0] resp_word_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 busy_o,
  output logic                 led_busy_o,
  output logic                 led_done_o,
  output logic [2:0]           dbg_state_o
);

  // Output handshake: resp_word_o is valid while resp_valid_o=1 and is held
  // unchanged until the cycle in which resp_valid_o & resp_ready_i are both 1.

  localparam int CNT_W = $clog2(RESP_BITS);
  localparam int SET_W = $clog2(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [RESP_BITS-1:0] shift_q, shift_d;
  logic [RESP_BITS-1:0] word_q, word_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic                 resp_s1_q, resp_s2_q;
  logic                 arb_clr_q, arb_clr_d;
  logic                 puf_in_q, puf_in_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 feedback;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    shift_d   = shift_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    settle_d  = settle_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load_i) begin
          lfsr_d = (seed_i == 8'h00) ? LFSR_SEED : seed_i;
        end else if (start_i) begin
          bit_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR:  state_d = S_LAUNCH;
      S_LAUNCH: begin
        settle_d = SET_W'(SETTLE_CYC - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_SAMPLE;
        else                settle_d = settle_q - SET_W'(1);
      end
      S_SAMPLE: begin
        shift_d = {shift_q[RESP_BITS-2:0], resp_s2_q};
        lfsr_d  = {lfsr_q[6:0], feedback};
        if (bit_cnt_q == CNT_W'(RESP_BITS - 1)) begin
          word_d  = shift_d;
          state_d = S_HOLD;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          state_d   = S_CLEAR;
        end
      end
      S_HOLD: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they align with the state register.
    arb_clr_d = (state_d == S_CLEAR);
    puf_in_d  = (state_d == S_LAUNCH) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    valid_d   = (state_d == S_HOLD);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      shift_q   <= '0;
      word_q    <= '0;
      bit_cnt_q <= '0;
      settle_q  <= '0;
      resp_s1_q <= 1'b0;
      resp_s2_q <= 1'b0;
      arb_clr_q <= 1'b0;
      puf_in_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      settle_q  <= settle_d;
      resp_s1_q <= puf_resp_i;
      resp_s2_q <= resp_s1_q;
      arb_clr_q <= arb_clr_d;
      puf_in_q  <= puf_in_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign ch_o         = lfsr_q;
  assign puf_in_o     = puf_in_q;
  assign arb_clr_o    = arb_clr_q;
  assign resp_word_o  = word_q;
  assign resp_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign led_busy_o   = busy_q;
  assign led_done_o   = valid_q;
  assign dbg_state_o  = state_q;

endmodule
